systolic_pe_ws: RTL and testbench

Second-generation parametrised systolic PE for the MAC array. Weights are double-buffered (a shadow register loads through the chain while the active weight computes) and data carries a valid bit. Supports signed/unsigned arithmetic and optional saturation. Two run-time modes: weight-stationary (partial sums flow through acc_in→acc_out) and output-stationary (local accumulator, drained on command). Instantiated in a 2-D grid; data flows east, weights and partial sums flow south.

---
 rtl/systolic_pe_ws.sv | 170 +++++++++++++++++
 tb/tb_systolic_pe_ws.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe_ws.sv
// Second-generation systolic MAC processing element: double-buffered weights,
// valid-qualified data, selectable WS/OS dataflow, signed/unsigned, optional saturation.
module systolic_pe_ws #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 32,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                data_valid_in,
  input  logic [WEIGHT_W-1:0] weight_in,
  input  logic                weight_load,
  input  logic                weight_swap,
  input  logic [ACC_W-1:0]    acc_in,
  input  logic                acc_valid_in,
  input  logic                drain,
  output logic [DATA_W-1:0]   data_out,
  output logic                data_valid_out,
  output logic [WEIGHT_W-1:0] weight_out,
  output logic [ACC_W-1:0]    acc_out,
  output logic                acc_valid_out,
  output logic                ovf
);

  localparam int PW = DATA_W + WEIGHT_W;

  logic [DATA_W-1:0]   dataOut_q, dataOut_d;
  logic                dataValidOut_q, dataValidOut_d;
  logic [WEIGHT_W-1:0] shadow_q, shadow_d;
  logic [WEIGHT_W-1:0] active_q, active_d;
  logic [PW-1:0]       prod_q, prod_d;
  logic                v1_q, v1_d;
  logic [ACC_W-1:0]    localAcc_q, localAcc_d;
  logic [ACC_W-1:0]    accOut_q, accOut_d;
  logic                accValidOut_q, accValidOut_d;
  logic                ovf_q, ovf_d;

  logic [PW-1:0]       dataX, weightX;
  logic [ACC_W:0]      prodX;
  logic [ACC_W:0]      wsSum, osSum;
  logic [ACC_W-1:0]    osNext;

  // Adds an (ACC_W+1)-bit extended product to an accumulator; MSB of the
  // returned value is the overflow indication, low ACC_W bits the result.
  function automatic logic [ACC_W:0] addSat(input logic [ACC_W-1:0] a,
                                            input logic [ACC_W:0]   px);
    logic [ACC_W:0]   ax;
    logic [ACC_W:0]   sum;
    logic             ov;
    logic [ACC_W-1:0] res;
    ax  = {(SIGNED ? a[ACC_W-1] : 1'b0), a};
    sum = ax + px;
    if (SIGNED) begin
      ov = (ax[ACC_W-1] == px[ACC_W-1]) && (sum[ACC_W-1] != ax[ACC_W-1]);
    end else begin
      ov = sum[ACC_W];
    end
    res = sum[ACC_W-1:0];
    if (ov && SATURATE) begin
      if (SIGNED) begin
        res = ax[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        res = '1;
      end
    end
    return {ov, res};
  endfunction

  always_comb begin
    dataOut_d      = data_in;
    dataValidOut_d = data_valid_in;
    shadow_d       = weight_load ? weight_in : shadow_q;
    active_d       = weight_swap ? shadow_q : active_q;
  end

  // Operands are widened to the full product width so a single multiply
  // serves both the signed and unsigned builds.
  always_comb begin
    dataX   = '0;
    weightX = '0;
    dataX[DATA_W-1:0]     = data_in;
    weightX[WEIGHT_W-1:0] = active_q;
    if (SIGNED && data_in[DATA_W-1]) begin
      dataX[PW-1:DATA_W] = '1;
    end
    if (SIGNED && active_q[WEIGHT_W-1]) begin
      weightX[PW-1:WEIGHT_W] = '1;
    end
    prod_d = dataX * weightX;
    v1_d   = data_valid_in;
  end

  always_comb begin
    prodX = '0;
    prodX[PW-1:0] = prod_q;
    if (SIGNED && prod_q[PW-1]) begin
      prodX[ACC_W:PW] = '1;
    end
  end

  assign wsSum = addSat(acc_in, prodX);
  assign osSum = addSat(localAcc_q, prodX);

  // Stage 2: passthrough of the north partial sum is the default in both
  // modes; only a valid product (WS) or a drain (OS) replaces it.
  always_comb begin
    accOut_d      = acc_in;
    accValidOut_d = acc_valid_in;
    localAcc_d    = localAcc_q;
    ovf_d         = ovf_q;
    osNext        = localAcc_q;
    if (!mode) begin
      if (v1_q) begin
        accOut_d = wsSum[ACC_W-1:0];
        ovf_d    = ovf_q | wsSum[ACC_W];
      end
    end else begin
      if (v1_q) begin
        osNext = osSum[ACC_W-1:0];
        ovf_d  = ovf_q | osSum[ACC_W];
      end
      if (drain) begin
        accOut_d      = osNext;
        accValidOut_d = 1'b1;
        localAcc_d    = '0;
      end else begin
        localAcc_d = osNext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dataOut_q      <= '0;
      dataValidOut_q <= 1'b0;
      shadow_q       <= '0;
      active_q       <= '0;
      prod_q         <= '0;
      v1_q           <= 1'b0;
      localAcc_q     <= '0;
      accOut_q       <= '0;
      accValidOut_q  <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      dataOut_q      <= dataOut_d;
      dataValidOut_q <= dataValidOut_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      prod_q         <= prod_d;
      v1_q           <= v1_d;
      localAcc_q     <= localAcc_d;
      accOut_q       <= accOut_d;
      accValidOut_q  <= accValidOut_d;
      ovf_q          <= ovf_d;
    end
  end

  // The shadow is visible to the south PE so each load advances the chain one hop.
  assign weight_out     = shadow_q;
  assign data_out       = dataOut_q;
  assign data_valid_out = dataValidOut_q;
  assign acc_out        = accOut_q;
  assign acc_valid_out  = accValidOut_q;
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_systolic_pe_ws.sv
// Directed bench for systolic_pe_ws: two chained default PEs plus 16-bit
// saturating, 16-bit wrapping and 32-bit unsigned variants sharing stimulus.
module tb_systolic_pe_ws;

  logic        clk;
  logic        reset;
  logic        mode;
  logic [7:0]  dataIn;
  logic        dataValidIn;
  logic [7:0]  weightIn;
  logic        weightLoad;
  logic        weightSwap;
  logic [31:0] accIn;
  logic        accValidIn;
  logic        drain;

  logic [7:0]  dataOut1, dataOut2, dataOutS, dataOutW, dataOutU;
  logic        dataValidOut1, dataValidOut2, dataValidOutS, dataValidOutW, dataValidOutU;
  logic [7:0]  weightOut1, weightOut2, weightOutS, weightOutW, weightOutU;
  logic [31:0] accOut1, accOut2, accOutU;
  logic [15:0] accOutS, accOutW;
  logic        accValidOut1, accValidOut2, accValidOutS, accValidOutW, accValidOutU;
  logic        ovf1, ovf2, ovfS, ovfW, ovfU;

  int checks = 0;
  int errors = 0;

  systolic_pe_ws u_pe1 (
    .clk(clk), .reset(reset), .mode(mode), .data_in(dataIn), .data_valid_in(dataValidIn),
    .weight_in(weightIn), .weight_load(weightLoad), .weight_swap(weightSwap),
    .acc_in(accIn), .acc_valid_in(accValidIn), .drain(drain),
    .data_out(dataOut1), .data_valid_out(dataValidOut1), .weight_out(weightOut1),
    .acc_out(accOut1), .acc_valid_out(accValidOut1), .ovf(ovf1));

  systolic_pe_ws u_pe2 (
    .clk(clk), .reset(reset), .mode(mode), .data_in(dataIn), .data_valid_in(dataValidIn),
    .weight_in(weightOut1), .weight_load(weightLoad), .weight_swap(weightSwap),
    .acc_in(accIn), .acc_valid_in(accValidIn), .drain(drain),
    .data_out(dataOut2), .data_valid_out(dataValidOut2), .weight_out(weightOut2),
    .acc_out(accOut2), .acc_valid_out(accValidOut2), .ovf(ovf2));

  systolic_pe_ws #(.ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .mode(mode), .data_in(dataIn), .data_valid_in(dataValidIn),
    .weight_in(weightIn), .weight_load(weightLoad), .weight_swap(weightSwap),
    .acc_in(accIn[15:0]), .acc_valid_in(accValidIn), .drain(drain),
    .data_out(dataOutS), .data_valid_out(dataValidOutS), .weight_out(weightOutS),
    .acc_out(accOutS), .acc_valid_out(accValidOutS), .ovf(ovfS));

  systolic_pe_ws #(.ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .mode(mode), .data_in(dataIn), .data_valid_in(dataValidIn),
    .weight_in(weightIn), .weight_load(weightLoad), .weight_swap(weightSwap),
    .acc_in(accIn[15:0]), .acc_valid_in(accValidIn), .drain(drain),
    .data_out(dataOutW), .data_valid_out(dataValidOutW), .weight_out(weightOutW),
    .acc_out(accOutW), .acc_valid_out(accValidOutW), .ovf(ovfW));

  systolic_pe_ws #(.SIGNED(1'b0), .SATURATE(1'b1)) u_uns (
    .clk(clk), .reset(reset), .mode(mode), .data_in(dataIn), .data_valid_in(dataValidIn),
    .weight_in(weightIn), .weight_load(weightLoad), .weight_swap(weightSwap),
    .acc_in(accIn), .acc_valid_in(accValidIn), .drain(drain),
    .data_out(dataOutU), .data_valid_out(dataValidOutU), .weight_out(weightOutU),
    .acc_out(accOutU), .acc_valid_out(accValidOutU), .ovf(ovfU));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic dv,
                               input logic [31:0] a, input logic av);
    dataIn      = d;
    dataValidIn = dv;
    accIn       = a;
    accValidIn  = av;
    tick();
  endtask

  task automatic loadAndSwap(input logic [7:0] w);
    weightIn   = w;
    weightLoad = 1'b1;
    tick();
    weightLoad = 1'b0;
    weightSwap = 1'b1;
    tick();
    weightSwap = 1'b0;
  endtask

  initial begin
    reset = 1'b0; mode = 1'b0; dataIn = '0; dataValidIn = 1'b0; weightIn = '0;
    weightLoad = 1'b0; weightSwap = 1'b0; accIn = '0; accValidIn = 1'b0; drain = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // Reset mid-stream
    loadAndSwap(8'd9);
    applyStimulus(8'd3, 1'b1, 32'd1, 1'b1);
    reset = 1'b0;
    tick();
    checkOutput("rst_acc_out", 64'(accOut1), 64'd0);
    checkOutput("rst_acc_valid", 64'(accValidOut1), 64'd0);
    checkOutput("rst_data_out", 64'(dataOut1), 64'd0);
    checkOutput("rst_data_valid", 64'(dataValidOut1), 64'd0);
    checkOutput("rst_weight_out", 64'(weightOut1), 64'd0);
    checkOutput("rst_ovf", 64'(ovf1), 64'd0);
    reset = 1'b1;
    applyStimulus(8'd5, 1'b1, 32'd0, 1'b0);
    applyStimulus(8'd0, 1'b0, 32'd7, 1'b1);
    checkOutput("rst_active_zero", 64'(accOut1), 64'd7);

    // Weight chain through two PEs
    weightLoad = 1'b1;
    weightIn = 8'h03;
    tick();
    weightIn = 8'h05;
    tick();
    weightLoad = 1'b0;
    checkOutput("chain_shadow1", 64'(weightOut1), 64'h5);
    checkOutput("chain_shadow2", 64'(weightOut2), 64'h3);
    weightSwap = 1'b1;
    tick();
    weightSwap = 1'b0;
    applyStimulus(8'd1, 1'b1, 32'd0, 1'b0);
    applyStimulus(8'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("chain_active1", 64'(accOut1), 64'd5);
    checkOutput("chain_active2", 64'(accOut2), 64'd3);
    weightLoad = 1'b1;
    weightSwap = 1'b1;
    weightIn = 8'h07;
    tick();
    weightLoad = 1'b0;
    weightSwap = 1'b0;
    checkOutput("ldswap_shadow1", 64'(weightOut1), 64'h7);
    checkOutput("ldswap_shadow2", 64'(weightOut2), 64'h5);
    applyStimulus(8'd1, 1'b1, 32'd0, 1'b0);
    applyStimulus(8'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("ldswap_active1", 64'(accOut1), 64'd5);
    checkOutput("ldswap_active2", 64'(accOut2), 64'd3);

    // WS signed: -3 * 4 + 100
    loadAndSwap(8'hFD);
    applyStimulus(8'd4, 1'b1, 32'd0, 1'b0);
    checkOutput("fwd_data", 64'(dataOut1), 64'd4);
    checkOutput("fwd_valid", 64'(dataValidOut1), 64'd1);
    applyStimulus(8'd0, 1'b0, 32'd100, 1'b1);
    checkOutput("ws_sum", 64'(accOut1), 64'd88);
    checkOutput("ws_valid", 64'(accValidOut1), 64'd1);
    applyStimulus(8'd0, 1'b0, 32'd55, 1'b0);
    checkOutput("ws_pass", 64'(accOut1), 64'd55);
    checkOutput("ws_pass_valid", 64'(accValidOut1), 64'd0);

    // OS accumulate and drain: 2*(1+2+3+4)
    loadAndSwap(8'd2);
    mode = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b1, 32'd0, 1'b0);
    drain = 1'b1;
    applyStimulus(8'd0, 1'b0, 32'd0, 1'b0);
    drain = 1'b0;
    checkOutput("os_drain", 64'(accOut1), 64'd20);
    checkOutput("os_drain_valid", 64'(accValidOut1), 64'd1);
    applyStimulus(8'd0, 1'b0, 32'h1234, 1'b1);
    checkOutput("os_pass", 64'(accOut1), 64'h1234);
    drain = 1'b1;
    applyStimulus(8'd0, 1'b0, 32'd0, 1'b0);
    drain = 1'b0;
    checkOutput("os_drain_empty", 64'(accOut1), 64'd0);
    checkOutput("os_drain_empty_valid", 64'(accValidOut1), 64'd1);
    mode = 1'b0;
    drain = 1'b1;
    applyStimulus(8'd0, 1'b0, 32'd9, 1'b0);
    drain = 1'b0;
    checkOutput("ws_drain_ignored", 64'(accOut1), 64'd9);
    checkOutput("ws_drain_ignored_valid", 64'(accValidOut1), 64'd0);

    // Saturation vs wrap at 16 bits
    loadAndSwap(8'd1);
    applyStimulus(8'd127, 1'b1, 32'd0, 1'b0);
    applyStimulus(8'd0, 1'b0, 32'd32760, 1'b1);
    checkOutput("sat_pos", 64'(accOutS), 64'h7FFF);
    checkOutput("sat_ovf", 64'(ovfS), 64'd1);
    checkOutput("wrap_pos", 64'(accOutW), 64'h8077);
    checkOutput("wrap_ovf", 64'(ovfW), 64'd1);
    checkOutput("wide_no_ovf_sum", 64'(accOut1), 64'd32887);
    checkOutput("wide_no_ovf", 64'(ovf1), 64'd0);
    applyStimulus(8'd0, 1'b0, 32'd5, 1'b1);
    checkOutput("sat_pass", 64'(accOutS), 64'd5);
    checkOutput("sat_ovf_sticky", 64'(ovfS), 64'd1);
    applyStimulus(8'h80, 1'b1, 32'd0, 1'b0);
    applyStimulus(8'd0, 1'b0, 32'hFFFF8008, 1'b1);
    checkOutput("sat_neg", 64'(accOutS), 64'h8000);
    checkOutput("wrap_neg", 64'(accOutW), 64'h7F88);

    // Unsigned operands
    loadAndSwap(8'd255);
    applyStimulus(8'd255, 1'b1, 32'd0, 1'b0);
    applyStimulus(8'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("uns_prod", 64'(accOutU), 64'd65025);
    checkOutput("uns_no_ovf", 64'(ovfU), 64'd0);
    checkOutput("signed_prod", 64'(accOut1), 64'd1);
    applyStimulus(8'd255, 1'b1, 32'd0, 1'b0);
    applyStimulus(8'd0, 1'b0, 32'hFFFFFFFF, 1'b1);
    checkOutput("uns_sat", 64'(accOutU), 64'hFFFFFFFF);
    checkOutput("uns_ovf", 64'(ovfU), 64'd1);
    checkOutput("signed_wrap_zero", 64'(accOut1), 64'd0);

    // Reset clears the sticky flag
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("rst_ovf_sat", 64'(ovfS), 64'd0);
    checkOutput("rst_ovf_uns", 64'(ovfU), 64'd0);
    checkOutput("rst_acc_uns", 64'(accOutU), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
